// File: rtl/tetris_input_pkg.sv
// Shared definitions for the Tetris button front-end: command bit indices,
// one-hot command constants, hold-FSM state encoding and the event priority picker.
package tetris_input_pkg;

  localparam int unsigned NUM_BTN   = 4;
  localparam int unsigned CMD_LEFT  = 0;
  localparam int unsigned CMD_RIGHT = 1;
  localparam int unsigned CMD_ROT   = 2;
  localparam int unsigned CMD_DROP  = 3;

  typedef logic [NUM_BTN-1:0] cmd_t;

  localparam cmd_t CMD_NONE_OH  = 4'b0000;
  localparam cmd_t CMD_LEFT_OH  = 4'b0001;
  localparam cmd_t CMD_RIGHT_OH = 4'b0010;
  localparam cmd_t CMD_ROT_OH   = 4'b0100;
  localparam cmd_t CMD_DROP_OH  = 4'b1000;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  // Single winner among simultaneous events: drop > rotate > left > right.
  function automatic cmd_t prio_pick(input cmd_t evt);
    cmd_t win;
    win = CMD_NONE_OH;
    if (evt[CMD_DROP])       win = CMD_DROP_OH;
    else if (evt[CMD_ROT])   win = CMD_ROT_OH;
    else if (evt[CMD_LEFT])  win = CMD_LEFT_OH;
    else if (evt[CMD_RIGHT]) win = CMD_RIGHT_OH;
    return win;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, stable-level debounce filter and press pulse.
// The stable level is exported only when AUTO_REPEAT_EN is defined.
module btn_debounce #(
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
`ifdef AUTO_REPEAT_EN
  output logic o_stable,
`endif
  output logic o_rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || ((DEBOUNCE_CYCLES - 1) >> CNT_W) != 32'd0) begin : g_bad_param
    $error("btn_debounce: DEBOUNCE_CYCLES must be >=1 and DEBOUNCE_CYCLES-1 must fit in CNT_W bits");
  end

  logic             r_meta;
  logic             r_sync;
  logic             r_stable;
  logic             r_rise;
  logic [CNT_W-1:0] r_cnt;

  // Accept a new level only after it has differed from stable for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_meta <= i_btn;
      r_sync <= r_meta;
      r_rise <= 1'b0;
      if (r_sync == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_sync;
        r_rise   <= r_sync;
        r_cnt    <= '0;
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  assign o_stable = r_stable;
`endif
  assign o_rise = r_rise;

endmodule

// File: rtl/button_input_ctrl.sv
// Tetris button front-end: four debounced buttons, priority pick and a hold FSM
// that keeps one command until acknowledged. Define AUTO_REPEAT_EN for left/right auto-repeat.
module button_input_ctrl
  import tetris_input_pkg::*;
#(
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 8000000,
  parameter int unsigned REPEAT_RATE     = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn_in,
  output logic [3:0] controller_out,
  output logic       cmd_valid,
  input  logic       cmd_ack
);

  if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_rep
    $error("button_input_ctrl: REPEAT_DELAY and REPEAT_RATE must be >=1");
  end

  cmd_t   w_rise;
  cmd_t   w_evt;
  cmd_t   w_win;
  cmd_t   w_cmd_nxt;
  cmd_t   r_cmd;
  state_t r_state;
  state_t w_state_nxt;

`ifdef AUTO_REPEAT_EN
  cmd_t w_stable;
`endif

  for (genvar g = 0; g < int'(NUM_BTN); g++) begin : g_btn
    btn_debounce #(
      .CNT_W           (CNT_W),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
      .clk      (clk),
      .reset    (reset),
      .i_btn    (btn_in[g]),
`ifdef AUTO_REPEAT_EN
      .o_stable (w_stable[g]),
`endif
      .o_rise   (w_rise[g])
    );
  end

`ifdef AUTO_REPEAT_EN
  if (((REPEAT_DELAY - 1) >> CNT_W) != 32'd0 || ((REPEAT_RATE - 1) >> CNT_W) != 32'd0) begin : g_bad_rep_w
    $error("button_input_ctrl: REPEAT_DELAY-1 and REPEAT_RATE-1 must fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] REP_FIRST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_NEXT  = CNT_W'(REPEAT_RATE - 1);

  logic [CNT_W-1:0] r_rep_cnt;
  logic             r_rep_first;
  logic             w_rep_hold;
  logic             w_rep_evt;

  // Repeat only while exactly one of left/right is held on its own.
  assign w_rep_hold = (w_stable == CMD_LEFT_OH) || (w_stable == CMD_RIGHT_OH);
  assign w_rep_evt  = w_rep_hold && (r_rep_cnt == (r_rep_first ? REP_FIRST : REP_NEXT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b1;
    end else if (!w_rep_hold || (|w_rise)) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b1;
    end else if (w_rep_evt) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b0;
    end else if (r_rep_cnt != '1) begin
      r_rep_cnt <= r_rep_cnt + 1'b1;
    end
  end

  assign w_evt = w_rise | (w_rep_evt ? w_stable : CMD_NONE_OH);
`else
  assign w_evt = w_rise;
`endif

  assign w_win = prio_pick(w_evt);

  // Hold FSM: an event is only taken when idle or together with the ack of the held command.
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_nxt   = r_cmd;
    case (r_state)
      IDLE: begin
        if (|w_evt) begin
          w_cmd_nxt   = w_win;
          w_state_nxt = PEND;
        end
      end
      PEND: begin
        if (cmd_ack) begin
          if (|w_evt) begin
            w_cmd_nxt = w_win;
          end else begin
            w_cmd_nxt   = CMD_NONE_OH;
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_cmd_nxt   = CMD_NONE_OH;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cmd   <= CMD_NONE_OH;
    end else begin
      r_state <= w_state_nxt;
      r_cmd   <= w_cmd_nxt;
    end
  end

  assign controller_out = r_cmd;
  assign cmd_valid      = (r_state == PEND);

endmodule

// File: tb/tb_button_input_ctrl.sv
// Directed bench for button_input_ctrl with DEBOUNCE_CYCLES=4, REPEAT_DELAY=8,
// REPEAT_RATE=3, CNT_W=4; repeat expectations follow AUTO_REPEAT_EN.
module tb_button_input_ctrl;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DEB    = 4;
  localparam int unsigned RDELAY = 8;
  localparam int unsigned RRATE  = 3;
  localparam int          LAT    = DEB + 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_in;
  logic [3:0] controller_out;
  logic       cmd_valid;
  logic       cmd_ack;

  int n_pass   = 0;
  int n_checks = 0;
  int ev_tick[$];
  int exp_tick[$];

  always #5 clk = ~clk;

  button_input_ctrl #(
    .CNT_W           (CNT_W),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RDELAY),
    .REPEAT_RATE     (RRATE)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .btn_in         (btn_in),
    .controller_out (controller_out),
    .cmd_valid      (cmd_valid),
    .cmd_ack        (cmd_ack)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_out(input string tag, input logic [3:0] exp_out, input logic exp_v);
    check({tag, "_out"}, 32'(controller_out), 32'(exp_out));
    check({tag, "_valid"}, 32'(cmd_valid), 32'(exp_v));
  endtask

  task automatic ack_once();
    cmd_ack = 1'b1;
    tick(1);
    cmd_ack = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    btn_in  = 4'b0000;
    cmd_ack = 1'b0;
    tick(2);
    check_out("reset", 4'b0000, 1'b0);
    reset = 1'b0;
    tick(2);

    // 1: steady left press, latency and hold until ack
    btn_in = 4'b0001;
    tick(LAT - 1);
    check_out("t1_early", 4'b0000, 1'b0);
    tick(1);
    check_out("t1_lat", 4'b0001, 1'b1);
    btn_in = 4'b0000;
    tick(3);
    check_out("t1_hold", 4'b0001, 1'b1);
    ack_once();
    check_out("t1_ack", 4'b0000, 1'b0);
    tick(10);
    check_out("t1_release", 4'b0000, 1'b0);

    // 2: short rotate glitch filtered, 4-cycle pulse accepted
    btn_in = 4'b0100;
    tick(3);
    btn_in = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      check("t2_glitch_valid", 32'(cmd_valid), 32'd0);
    end
    btn_in = 4'b0100;
    tick(4);
    btn_in = 4'b0000;
    tick(LAT - 5);
    check_out("t2_early", 4'b0000, 1'b0);
    tick(1);
    check_out("t2_pulse", 4'b0100, 1'b1);
    ack_once();
    check_out("t2_ack", 4'b0000, 1'b0);
    tick(10);

    // 3: simultaneous drop/rotate/left -> drop only; ack while idle ignored
    btn_in = 4'b1101;
    tick(LAT);
    check_out("t3_prio", 4'b1000, 1'b1);
    ack_once();
    check_out("t3_ack", 4'b0000, 1'b0);
    tick(5);
    check_out("t3_discard", 4'b0000, 1'b0);
    ack_once();
    check_out("t3_idle_ack", 4'b0000, 1'b0);
    btn_in = 4'b0000;
    tick(10);

    // 4: event dropped while pending; ack together with event loads back-to-back
    btn_in = 4'b0001;
    tick(LAT);
    check_out("t4_left", 4'b0001, 1'b1);
    btn_in = 4'b0011;
    tick(LAT + 1);
    check_out("t4_drop_right", 4'b0001, 1'b1);
    btn_in = 4'b0111;
    tick(LAT - 1);
    cmd_ack = 1'b1;
    tick(1);
    cmd_ack = 1'b0;
    check_out("t4_b2b", 4'b0100, 1'b1);
    tick(1);
    check_out("t4_b2b_hold", 4'b0100, 1'b1);
    ack_once();
    check_out("t4_ack", 4'b0000, 1'b0);
    btn_in = 4'b0000;
    tick(10);

    // 5: async reset mid-PEND and mid-debounce; held buttons re-debounced after release
    btn_in = 4'b0001;
    tick(LAT);
    check_out("t5_pend", 4'b0001, 1'b1);
    btn_in = 4'b0011;
    tick(2);
    #2;
    reset = 1'b1;
    #1;
    check_out("t5_async", 4'b0000, 1'b0);
    tick(1);
    check_out("t5_in_reset", 4'b0000, 1'b0);
    reset = 1'b0;
    tick(LAT - 1);
    check_out("t5_early", 4'b0000, 1'b0);
    tick(1);
    check_out("t5_after", 4'b0001, 1'b1);
    ack_once();
    btn_in = 4'b0000;
    tick(10);
    check_out("t5_idle", 4'b0000, 1'b0);

    // 6: hold left, ack each command the cycle it appears
    btn_in = 4'b0001;
    for (int t = 1; t <= 22; t++) begin
      tick(1);
      if (cmd_valid) begin
        ev_tick.push_back(t);
        check("t6_cmd", 32'(controller_out), 32'h1);
        cmd_ack = 1'b1;
      end else begin
        cmd_ack = 1'b0;
      end
    end
    cmd_ack = 1'b0;
`ifdef AUTO_REPEAT_EN
    exp_tick = '{LAT, LAT + 8, LAT + 11, LAT + 14};
`else
    exp_tick = '{LAT};
`endif
    check("t6_count", 32'(ev_tick.size()), 32'(exp_tick.size()));
    for (int i = 0; i < exp_tick.size(); i++) begin
      check("t6_tick", 32'((i < ev_tick.size()) ? ev_tick[i] : -1), 32'(exp_tick[i]));
    end
    btn_in = 4'b0000;
    tick(10);
    check_out("t6_end", 4'b0000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
